mips_controle_multiciclo: RTL

Main control unit for the multicycle MIPS core. It receives the opcode and function fields that the datapath decodes from its instruction register, and it drives every control strobe back into that datapath (mux selects, register enables, memory write, ALU operation class) through a Moore state machine. It is the controller half of the controller/datapath pair, and the top level instantiates it alongside the datapath on the same clock and reset.

---
 rtl/mips_controle_multiciclo.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mips_controle_multiciclo.sv
// Main control unit for the multicycle MIPS core.
// Moore FSM: every strobe decodes from the state register. The one exception is
// instr_done in DECODE, which also depends on OP so an illegal opcode retires at once.
module mips_controle_multiciclo (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Branch,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiEx   = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11
  } state_e;

  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpRtyp = 6'b000000;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;

  state_e state_q, state_d;
  logic   op_legal;

  // Funct is decoded by the datapath ALU decoder, not here.
  logic funct_unused;
  assign funct_unused = ^Funct;

  assign op_legal = (OP == OpLw) || (OP == OpSw) || (OP == OpRtyp) ||
                    (OP == OpBeq) || (OP == OpAddi) || (OP == OpJ);

  assign state = state_q;

  // State register; reset forces FETCH without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; OP is only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:   state_d = StDecode;
      StDecode: begin
        unique case (OP)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtyp:     state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;  // illegal opcode retires as a NOP
        endcase
      end
      StMemAdr:  state_d = (OP == OpLw) ? StMemRead : StMemWrite;
      StMemRead: state_d = StMemWb;
      StExecute: state_d = StAluWb;
      StAddiEx:  state_d = StAddiWb;
      default:   state_d = StFetch;       // write-back/final states and unused codes
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    Branch     = 1'b0;
    ALUOp      = 2'b00;
    instr_done = 1'b0;
    unique case (state_q)
      StFetch: begin
        ALUSrcB = 2'b01;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      StDecode: begin
        // Branch target precomputed into ALUOut.
        ALUSrcB    = 2'b11;
        instr_done = ~op_legal;
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRead: IorD = 1'b1;
      StMemWb: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      StMemWrite: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      StExecute: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      StAluWb: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSrc      = 2'b01;
        Branch     = 1'b1;
        instr_done = 1'b1;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StAddiWb: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      StJump: begin
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;  // unused codes drive nothing
    endcase
  end

endmodule
